// File: rtl/cxu_pkg.sv
// cxu_pkg: shared CXU status encodings
package cxu_pkg;
  typedef enum logic [3:0] {
    CXU_STATUS_OK     = 4'd0,
    CXU_STATUS_ERROR  = 4'd1,
    CXU_STATUS_OFF    = 4'd2,
    CXU_STATUS_CUSTOM = 4'd8
  } cxu_status_e;
endpackage

// File: rtl/cxu_resp_fifo.sv
// cxu_resp_fifo: DEPTH-entry response FIFO; push while full is allowed only alongside a pop
module cxu_resp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign empty = cnt == '0;
  assign full = cnt == CW'(DEPTH);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = empty ? '0 : mem[rp];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= nxt(wp);
      if (do_pop) rp <= nxt(rp);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/shift_reg.sv
// shift_reg: N-stage enable-gated register chain; N=0 degenerates to a wire
module shift_reg #(
  parameter int W = 1,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  if (N == 0) begin : g_wire
    assign q = d;
  end else begin : g_reg
    logic [W-1:0] r [N];
    always_ff @(posedge clk or posedge rst)
      if (rst) for (int i = 0; i < N; i++) r[i] <= '0;
      else if (en) begin
        r[0] <= d;
        for (int i = 1; i < N; i++) r[i] <= r[i-1];
      end
    assign q = r[N-1];
  end
endmodule

// File: rtl/cvt02_cxu.sv
// cvt02_cxu: L0 CXU adapter with latency pipeline and response FIFO; CVT02_CXU_ID_CHECK_EN enables CXU ID range checking
module cvt02_cxu import cxu_pkg::*; #(
  parameter int CXU_N_CXUS    = 1,
  parameter int CXU_CXU_ID_W  = 8,
  parameter int CXU_FUNC_ID_W = 10,
  parameter int CXU_DATA_W    = 32,
  parameter int CXU_STATUS_W  = 4,
  parameter int CXU_LATENCY   = 0,
  parameter int CXU_REQ_ID_W  = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_en,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [CXU_REQ_ID_W-1:0]  req_id,
  input  logic [CXU_CXU_ID_W-1:0]  req_cxu,
  input  logic [CXU_FUNC_ID_W-1:0] req_func,
  input  logic [CXU_DATA_W-1:0]    req_data0,
  input  logic [CXU_DATA_W-1:0]    req_data1,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [CXU_REQ_ID_W-1:0]  resp_id,
  output logic [CXU_STATUS_W-1:0]  resp_status,
  output logic [CXU_DATA_W-1:0]    resp_data,
  output logic                     t_req_valid,
  output logic [CXU_CXU_ID_W-1:0]  t_req_cxu,
  output logic [CXU_FUNC_ID_W-1:0] t_req_func,
  output logic [CXU_DATA_W-1:0]    t_req_data0,
  output logic [CXU_DATA_W-1:0]    t_req_data1,
  input  logic [CXU_STATUS_W-1:0]  t_resp_status,
  input  logic [CXU_DATA_W-1:0]    t_resp_data
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = CXU_REQ_ID_W + CXU_STATUS_W + CXU_DATA_W;
  localparam int PW = FW + 1;
  logic accept, pop, push, id_ok, full, empty;
  logic [CW-1:0] outstanding;
  logic [PW-1:0] pipe_d, pipe_q;
`ifdef CVT02_CXU_ID_CHECK_EN
  assign id_ok = 32'(req_cxu) < CXU_N_CXUS;
`else
  assign id_ok = 1'b1;
`endif
  assign pop = resp_valid & resp_ready & clk_en;
  assign req_ready = (outstanding < CW'(FIFO_DEPTH)) | ((outstanding == CW'(FIFO_DEPTH)) & pop);
  assign accept = req_valid & req_ready & clk_en;
  assign t_req_valid = accept & id_ok;
  assign t_req_cxu = req_cxu;
  assign t_req_func = req_func;
  assign t_req_data0 = req_data0;
  assign t_req_data1 = req_data1;
  assign pipe_d = {accept, req_id, id_ok ? t_resp_status : CXU_STATUS_W'(CXU_STATUS_ERROR),
                   id_ok ? t_resp_data : '0};
  shift_reg #(.W(PW), .N(CXU_LATENCY)) u_pipe (
    .clk(clk), .rst(rst), .en(clk_en), .d(pipe_d), .q(pipe_q)
  );
  // full guard is redundant with the outstanding limit but keeps the FIFO self-protecting
  assign push = pipe_q[PW-1] & clk_en & (~full | pop);
  cxu_resp_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(pipe_q[FW-1:0]),
    .dout({resp_id, resp_status, resp_data}), .full(full), .empty(empty)
  );
  assign resp_valid = ~empty;
  always_ff @(posedge clk or posedge rst)
    if (rst) outstanding <= '0;
    else outstanding <= outstanding + CW'(accept) - CW'(pop);
endmodule

// File: tb/tb_cvt02_cxu.sv
// tb_cvt02_cxu: three adapter instances checked against a queue-based response model
module tb_cvt02_cxu;
  import cxu_pkg::*;
  localparam int NI = 3;
  typedef struct {
    logic [3:0]  id;
    logic [3:0]  st;
    logic [31:0] d;
    int          e;
  } exp_t;
  logic clk = 0, rst = 1, clk_en = 1;
  logic req_valid[NI], req_ready[NI], resp_valid[NI], resp_ready[NI], t_req_valid[NI];
  logic [3:0] req_id[NI], resp_id[NI], resp_status[NI], t_resp_status[NI];
  logic [7:0] req_cxu[NI], t_req_cxu[NI];
  logic [9:0] req_func[NI], t_req_func[NI];
  logic [31:0] req_data0[NI], req_data1[NI], resp_data[NI];
  logic [31:0] t_req_data0[NI], t_req_data1[NI], t_resp_data[NI];
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;

  task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = (g == 0) ? 0 : 2;
    localparam int D = (g == 2) ? 3 : 4;
    cvt02_cxu #(
      .CXU_N_CXUS(2), .CXU_CXU_ID_W(8), .CXU_FUNC_ID_W(10), .CXU_DATA_W(32),
      .CXU_STATUS_W(4), .CXU_LATENCY(L), .CXU_REQ_ID_W(4), .FIFO_DEPTH(D)
    ) u_dut (
      .clk(clk), .rst(rst), .clk_en(clk_en),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_id(req_id[g]),
      .req_cxu(req_cxu[g]), .req_func(req_func[g]),
      .req_data0(req_data0[g]), .req_data1(req_data1[g]),
      .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]), .resp_id(resp_id[g]),
      .resp_status(resp_status[g]), .resp_data(resp_data[g]),
      .t_req_valid(t_req_valid[g]), .t_req_cxu(t_req_cxu[g]), .t_req_func(t_req_func[g]),
      .t_req_data0(t_req_data0[g]), .t_req_data1(t_req_data1[g]),
      .t_resp_status(t_resp_status[g]), .t_resp_data(t_resp_data[g])
    );
    // subordinate: result is the operand sum, status is the low function bits
    assign t_resp_data[g] = t_req_data0[g] + t_req_data1[g];
    assign t_resp_status[g] = t_req_func[g][3:0];

    // model: a response becomes visible L+1 enabled edges after its accept and leaves in order
    exp_t q[$];
    int ecyc = 0;
    initial forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        check($sformatf("rst_valid%0d", g), resp_valid[g], 0);
        check($sformatf("rst_ready%0d", g), req_ready[g], 1);
        check($sformatf("rst_fields%0d", g), {resp_id[g], resp_status[g], resp_data[g]}, 0);
      end else begin
        logic ev, pe, rr, acc, ok;
        ev = q.size() > 0 && q[0].e + L + 1 <= ecyc;
        check($sformatf("resp_valid%0d", g), resp_valid[g], ev);
        if (ev) begin
          check($sformatf("resp_id%0d", g), resp_id[g], q[0].id);
          check($sformatf("resp_status%0d", g), resp_status[g], q[0].st);
          check($sformatf("resp_data%0d", g), resp_data[g], q[0].d);
        end
        pe = ev & resp_ready[g] & clk_en;
        rr = q.size() < D || (q.size() == D && pe);
        check($sformatf("req_ready%0d", g), req_ready[g], rr);
        acc = req_valid[g] & rr & clk_en;
`ifdef CVT02_CXU_ID_CHECK_EN
        ok = req_cxu[g] < 2;
`else
        ok = 1'b1;
`endif
        check($sformatf("t_req_valid%0d", g), t_req_valid[g], acc & ok);
        check($sformatf("t_req_fwd%0d", g), {t_req_cxu[g], t_req_func[g], t_req_data0[g]},
              {req_cxu[g], req_func[g], req_data0[g]});
        if (pe) void'(q.pop_front());
        if (acc) q.push_back('{req_id[g], ok ? req_func[g][3:0] : CXU_STATUS_ERROR,
                               ok ? req_data0[g] + req_data1[g] : 32'd0, ecyc});
        if (clk_en) ecyc++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [3:0] id, input logic [7:0] cxu,
                       input logic [9:0] f, input logic [31:0] a, input logic [31:0] b);
    req_valid[i] = v;
    req_id[i] = id;
    req_cxu[i] = cxu;
    req_func[i] = f;
    req_data0[i] = a;
    req_data1[i] = b;
  endtask

  initial begin
    int n, s, k;
    for (int i = 0; i < NI; i++) begin
      drive(i, 0, 0, 0, 0, 0, 0);
      resp_ready[i] = 1;
    end
    repeat (2) step();
    check("reset_ready", req_ready[0], 1);
    check("reset_valid", resp_valid[0], 0);
    rst = 0;
    // zero latency: response on the cycle after accept
    resp_ready[0] = 0;
    drive(0, 1, 3, 0, 0, 32'h1000, 32'h0234);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("lat0_valid", resp_valid[0], 1);
    check("lat0_id", resp_id[0], 3);
    check("lat0_data", resp_data[0], 32'h1234);
    resp_ready[0] = 1;
    repeat (2) step();
    // fill to depth with responses blocked, then pop frees a slot the same cycle
    resp_ready[1] = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 4'(i), 1, 10'(i + 1), 32'(i * 16), 5);
      step();
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    #1;
    check("full_ready", req_ready[1], 0);
    repeat (3) step();
    resp_ready[1] = 1;
    drive(1, 1, 9, 0, 5, 32'h77, 1);
    #1;
    check("pop_ready", req_ready[1], 1);
    step();
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (6) step();
    // back-to-back stream through latency 2, depth 3
    n = 0;
    s = 0;
    for (int c = 0; c < 30; c++) begin
      drive(2, c < 20, 4'(c), 1, 10'(c % 7), 32'(c * 3), 32'h100);
      #1;
      if (c < 20 && !req_ready[2]) s++;
      if (resp_valid[2]) n++;
      step();
    end
    drive(2, 0, 0, 0, 0, 0, 0);
    check("stream_stalls", s, 0);
    check("stream_resps", n, 20);
    // clock enable low for five cycles mid-stream
    n = 0;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      clk_en = !(c >= 3 && c < 8);
      drive(1, k < 8, 4'(k), 0, 10'(k + 2), 32'(k), 32'h10);
      #1;
      if (req_valid[1] && req_ready[1] && clk_en) k++;
      if (resp_valid[1] && clk_en) n++;
      step();
    end
    clk_en = 1;
    drive(1, 0, 0, 0, 0, 0, 0);
    check("freeze_accepts", k, 8);
    check("freeze_resps", n, 8);
    // reset with three outstanding
    resp_ready[1] = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 4'(i + 5), 1, 3, 32'(i), 2);
      step();
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
    check("pre_rst_valid", resp_valid[1], 1);
    #1 rst = 1;
    #1;
    check("async_rst_valid", resp_valid[1], 0);
    check("async_rst_ready", req_ready[1], 1);
    repeat (2) step();
    rst = 0;
    resp_ready[1] = 1;
    n = 0;
    repeat (6) begin
      #1;
      if (resp_valid[1]) n++;
      step();
    end
    check("stale_resps", n, 0);
    // out-of-range CXU ID
    resp_ready[0] = 0;
    drive(0, 1, 7, 5, 2, 1, 2);
    #1;
`ifdef CVT02_CXU_ID_CHECK_EN
    check("idchk_tvalid", t_req_valid[0], 0);
`else
    check("idchk_tvalid", t_req_valid[0], 1);
`endif
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("idchk_id", resp_id[0], 7);
`ifdef CVT02_CXU_ID_CHECK_EN
    check("idchk_status", resp_status[0], CXU_STATUS_ERROR);
    check("idchk_data", resp_data[0], 0);
`else
    check("idchk_status", resp_status[0], 2);
    check("idchk_data", resp_data[0], 3);
`endif
    resp_ready[0] = 1;
    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
